// File: rtl/npc_arb_pkg.sv
// Shared types and constants for the NPC round-robin arbiter.
// Imported by the arbiter top level and its picker.
package npc_arb_pkg;

   localparam int NUM_REQ = 8;
   localparam int SEL_W   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      onehot = NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/npc_rr_arbiter8_pick8.sv
// Round-robin pick: rotate by ptr, priority-encode, unrotate.
// Purely combinational; idx is only meaningful while any is set.
module npc_rr_pick8
   import npc_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               any,
   output logic [SEL_W-1:0]   idx
);

   logic [NUM_REQ-1:0] rot;
   logic [SEL_W-1:0]   off;

   // rot[i] is the requester i positions after ptr; lowest set bit wins
   always_comb begin
      rot = '0;
      off = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rot[i] = req[SEL_W'(i) + ptr];
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = SEL_W'(i);
      end
      any = |req;
      idx = off + ptr;
   end

endmodule

// File: rtl/npc_rr_arbiter8.sv
// Round-robin owner of the NPC shared-port select.
// Select and grant are frozen for the whole transaction.
module npc_rr_arbiter8
   import npc_arb_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [SEL_W-1:0]   sel,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               done,
   output logic               done_o,
   output logic               err
);

   localparam logic [CNT_W-1:0] TO_LAST =
      CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   arb_state_e       state;
   logic [SEL_W-1:0] ptr;
   logic [CNT_W-1:0] cnt;

   logic             pick_any;
   logic [SEL_W-1:0] pick_idx;
   logic             to_hit;
   logic [SEL_W-1:0] ptr_next;

   npc_rr_pick8 u_pick (
      .req (req),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Timeout boundary: last WAIT cycle allowed without done
   assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

   // The requester just served drops to lowest priority
   assign ptr_next = sel + SEL_W'(1);

   // Transaction FSM with registered grant, select and pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         sel       <= '0;
         gnt       <= '0;
         out_valid <= 1'b0;
         done_o    <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
      end else begin
         done_o <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  sel       <= pick_idx;
                  gnt       <= onehot(pick_idx);
                  out_valid <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (done) begin
                     done_o <= 1'b1;
                     gnt    <= '0;
                     ptr    <= ptr_next;
                     state  <= IDLE;
                  end else begin
                     cnt   <= '0;
                     state <= WAIT;
                  end
               end else if (!req[sel]) begin
                  out_valid <= 1'b0;
                  gnt       <= '0;
                  ptr       <= ptr_next;
                  state     <= IDLE;
               end
            end
            WAIT: begin
               if (done) begin
                  done_o <= 1'b1;
                  gnt    <= '0;
                  ptr    <= ptr_next;
                  state  <= IDLE;
               end else if (to_hit) begin
                  err   <= 1'b1;
                  gnt   <= '0;
                  ptr   <= ptr_next;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               gnt       <= '0;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
